// File: rtl/macguffin_arbiter.sv
// macguffin_arbiter: round-robin share of one MacGuffin core between two AXI-Stream requesters
module macguffin_arbiter #(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s0_axis_tdata,
    input  logic              s0_axis_tvalid,
    output logic              s0_axis_tready,
    input  logic [DATA_W-1:0] s1_axis_tdata,
    input  logic              s1_axis_tvalid,
    output logic              s1_axis_tready,
    output logic [DATA_W-1:0] m0_axis_tdata,
    output logic              m0_axis_tvalid,
    input  logic              m0_axis_tready,
    output logic [DATA_W-1:0] m1_axis_tdata,
    output logic              m1_axis_tvalid,
    input  logic              m1_axis_tready,
    output logic [DATA_W-1:0] core_s_axis_tdata,
    output logic              core_s_axis_tvalid,
    input  logic              core_s_axis_tready,
    input  logic [DATA_W-1:0] core_m_axis_tdata,
    input  logic              core_m_axis_tvalid,
    output logic              core_m_axis_tready,
    output logic              busy,
    output logic [CNT_W-1:0]  blk_cnt0,
    output logic [CNT_W-1:0]  blk_cnt1
);
    typedef enum logic [2:0] {IDLE, ACCEPT, ISSUE, WAIT, DELIVER} state_t;
    state_t            state;
    logic              sel;
    logic              last;
    logic [DATA_W-1:0] blk;
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              m_ready;
    logic              acc;
    logic              dlv;
    always_comb begin
        s_valid = sel ? s1_axis_tvalid : s0_axis_tvalid;
        s_data  = sel ? s1_axis_tdata : s0_axis_tdata;
        m_ready = sel ? m1_axis_tready : m0_axis_tready;
        acc     = state == ACCEPT;
        dlv     = state == DELIVER;
    end
    // Outputs decode only registered state, so reset clears them immediately
    always_comb begin
        s0_axis_tready     = acc && !sel;
        s1_axis_tready     = acc && sel;
        core_s_axis_tvalid = state == ISSUE;
        core_s_axis_tdata  = (state == ISSUE) ? blk : '0;
        core_m_axis_tready = state == WAIT;
        m0_axis_tvalid     = dlv && !sel;
        m1_axis_tvalid     = dlv && sel;
        m0_axis_tdata      = (dlv && !sel) ? blk : '0;
        m1_axis_tdata      = (dlv && sel) ? blk : '0;
        busy               = state != IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            sel      <= 1'b0;
            last     <= 1'b1;
            blk      <= '0;
            blk_cnt0 <= '0;
            blk_cnt1 <= '0;
        end else begin
            case (state)
                IDLE: if (s0_axis_tvalid || s1_axis_tvalid) begin
                    sel   <= (s0_axis_tvalid && s1_axis_tvalid) ? ~last : s1_axis_tvalid;
                    state <= ACCEPT;
                end
                ACCEPT: if (s_valid) begin
                    blk   <= s_data;
                    state <= ISSUE;
                end else begin
                    state <= IDLE;
                end
                ISSUE: if (core_s_axis_tready) state <= WAIT;
                WAIT: if (core_m_axis_tvalid) begin
                    blk   <= core_m_axis_tdata;
                    state <= DELIVER;
                end
                DELIVER: if (m_ready) begin
                    last  <= sel;
                    state <= IDLE;
                    if (sel) blk_cnt1 <= blk_cnt1 + 1'b1;
                    else blk_cnt0 <= blk_cnt0 + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
